// File: rtl/mem_stage_pkg.sv
// Shared access-size encodings, FSM state type and helpers for the memory-access stage.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 8.
  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // A dword request on a 32-bit datapath is served as a full word.
  function automatic logic [1:0] eff_size(input logic [1:0] sz, input int data_w);
    return (data_w == 32 && sz == SZ_DWORD) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Byte-enabled single-port data memory: synchronous write, combinational read, no reset.
module mem_stage_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int NB    = DATA_W / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage with a configurable-latency data memory and branch resolution.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of silently aligning them.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int RD_W    = 5,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic              alu_branch,
  input  logic              control_branch,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] dataB,
  input  logic [RD_W-1:0]   rd,
  output logic              stall,
  output logic              out_valid,
  output logic [RD_W-1:0]   rd_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] newPC,
  output logic              PC_mux_control,
  output logic              misalign,
  output state_t            fsm_state
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic               h_read, h_write, h_uns, h_br;
  logic [1:0]         h_size;
  logic [DATA_W-1:0]  h_alu, h_pc, h_data;
  logic [RD_W-1:0]    h_rd;

  logic               c_read, c_write, c_uns, c_br;
  logic [1:0]         c_size;
  logic [DATA_W-1:0]  c_alu, c_pc, c_data;
  logic [RD_W-1:0]    c_rd;

  // Handshake: an op is taken on a rising edge with in_valid=1 and stall=0; upstream holds otherwise.
  logic accept, is_mem, finish_wait, complete, is_load, is_store, we;

  assign accept      = in_valid && (state == IDLE);
  assign is_mem      = mem_read | mem_write;
  assign finish_wait = (state == WAIT) && (cnt == CNT_W'(1));
  assign complete    = (accept && (!is_mem || MEM_LAT == 1)) || finish_wait;
  assign stall       = (state == WAIT);
  assign fsm_state   = state;

  // A waiting op completes from its captured copy; otherwise the live inputs are used.
  always_comb begin
    if (state == WAIT) begin
      c_read  = h_read;
      c_write = h_write;
      c_uns   = h_uns;
      c_br    = h_br;
      c_size  = h_size;
      c_alu   = h_alu;
      c_pc    = h_pc;
      c_data  = h_data;
      c_rd    = h_rd;
    end else begin
      c_read  = mem_read;
      c_write = mem_write;
      c_uns   = ld_unsigned;
      c_br    = alu_branch & control_branch;
      c_size  = size;
      c_alu   = alu;
      c_pc    = PC;
      c_data  = dataB;
      c_rd    = rd;
    end
  end

  assign is_load  = c_read;
  assign is_store = c_write & ~c_read;

  logic [1:0]        sz;
  logic [LB-1:0]     off_raw, low_mask, off;
  logic              trap;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata, rdata, shifted, ext;

  always_comb begin
    sz       = eff_size(c_size, DATA_W);
    off_raw  = c_alu[LB-1:0];
    low_mask = LB'((1 << sz) - 1);
`ifdef MEM_MISALIGN_TRAP_EN
    trap     = |(off_raw & low_mask);
    off      = off_raw;
`else
    trap     = 1'b0;
    off      = off_raw & ~low_mask;
`endif
    be       = NB'(((1 << (1 << sz)) - 1) << off);
    wdata    = c_data << {off, 3'b000};
    shifted  = rdata >> {off, 3'b000};
    case (sz)
      SZ_BYTE: ext = c_uns ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      SZ_HALF: ext = c_uns ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      SZ_WORD: ext = c_uns ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
  end

  assign we = complete && is_store && !trap && !rst;

  mem_stage_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .be   (be),
    .addr (c_alu[AW+LB-1:LB]),
    .wdata(wdata),
    .rdata(rdata)
  );

  // Address bits above the memory span wrap by design.
  logic unused_hi;
  assign unused_hi = ^c_alu[DATA_W-1:AW+LB];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      out_valid      <= 1'b0;
      PC_mux_control <= 1'b0;
      rd_out         <= '0;
      alu_out        <= '0;
      data_out       <= '0;
      newPC          <= '0;
    end else begin
      out_valid      <= complete;
      PC_mux_control <= complete & c_br;
      if (complete) begin
        rd_out   <= c_rd;
        alu_out  <= c_alu;
        newPC    <= c_pc;
        data_out <= (is_load && !trap) ? ext : '0;
      end
      case (state)
        IDLE: begin
          if (accept && is_mem && MEM_LAT > 1) begin
            state   <= WAIT;
            cnt     <= CNT_W'(MEM_LAT - 1);
            h_read  <= mem_read;
            h_write <= mem_write;
            h_uns   <= ld_unsigned;
            h_br    <= alu_branch & control_branch;
            h_size  <= size;
            h_alu   <= alu;
            h_pc    <= PC;
            h_data  <= dataB;
            h_rd    <= rd;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (finish_wait) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= complete & (c_read | c_write) & trap;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a MEM_LAT=1 and a MEM_LAT=4 instance share inputs, each with its own valid.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = RW + 3 * DW + 2;

  logic clk = 1'b0;
  logic rst;
  logic iv1, iv4, mem_read, mem_write, ld_unsigned, alu_branch, control_branch;
  logic [1:0]    size;
  logic [DW-1:0] alu, pc, data_b;
  logic [RW-1:0] rd;

  logic          stall1, ov1, pcm1, mis1, stall4, ov4, pcm4, mis4;
  logic [RW-1:0] rdo1, rdo4;
  logic [DW-1:0] alo1, dout1, npc1, alo4, dout4, npc4;
  state_t        st1, st4;

  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q4[$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .DEPTH(256), .RD_W(RW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .ld_unsigned(ld_unsigned), .alu_branch(alu_branch),
    .control_branch(control_branch), .alu(alu), .PC(pc), .dataB(data_b), .rd(rd),
    .stall(stall1), .out_valid(ov1), .rd_out(rdo1), .alu_out(alo1), .data_out(dout1),
    .newPC(npc1), .PC_mux_control(pcm1), .misalign(mis1), .fsm_state(st1)
  );

  mem_access_stage #(.DATA_W(DW), .DEPTH(256), .RD_W(RW), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .ld_unsigned(ld_unsigned), .alu_branch(alu_branch),
    .control_branch(control_branch), .alu(alu), .PC(pc), .dataB(data_b), .rd(rd),
    .stall(stall4), .out_valid(ov4), .rd_out(rdo4), .alu_out(alo4), .data_out(dout4),
    .newPC(npc4), .PC_mux_control(pcm4), .misalign(mis4), .fsm_state(st4)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [RW-1:0] r, input logic [DW-1:0] a,
                                         input logic [DW-1:0] d, input logic [DW-1:0] p,
                                         input logic pm, input logic mi);
    return {r, a, d, p, pm, mi};
  endfunction

  // Scoreboard side: every retired op is compared against the oldest expectation.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (exp_q1.size() == 0) check("spurious_out_lat1", 128'(ov1), 128'd0);
      else check("result_lat1", 128'({rdo1, alo1, dout1, npc1, pcm1, mis1}), 128'(exp_q1.pop_front()));
    end
    if (ov4 === 1'b1) begin
      if (exp_q4.size() == 0) check("spurious_out_lat4", 128'(ov4), 128'd0);
      else check("result_lat4", 128'({rdo4, alo4, dout4, npc4, pcm4, mis4}), 128'(exp_q4.pop_front()));
    end
  end

  // Drives one op at a falling edge, pushes its expectation and checks stall/valid timing.
  task automatic run_op(input int sel, input logic rdd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic ab, input logic cb,
                        input logic [DW-1:0] a, input logic [DW-1:0] p, input logic [DW-1:0] db,
                        input logic [RW-1:0] r, input logic [DW-1:0] exp_d,
                        input logic exp_pm, input logic exp_mis, input bit garbage);
    int lat;
    logic o, s, pm;
    lat = (sel == 4 && (rdd || wr)) ? 4 : 1;
    mem_read = rdd; mem_write = wr; size = sz; ld_unsigned = uns;
    alu_branch = ab; control_branch = cb; alu = a; pc = p; data_b = db; rd = r;
    if (sel == 4) begin
      iv4 = 1'b1;
      exp_q4.push_back(pack(r, a, exp_d, p, exp_pm, exp_mis));
    end else begin
      iv1 = 1'b1;
      exp_q1.push_back(pack(r, a, exp_d, p, exp_pm, exp_mis));
    end
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      o = (sel == 4) ? ov4 : ov1;
      s = (sel == 4) ? stall4 : stall1;
      if (i < lat) begin
        check("stall_while_waiting", 128'(s), 128'd1);
        check("no_early_valid", 128'(o), 128'd0);
        if (garbage) begin
          iv4 = 1'b1;
          alu = $urandom();
          data_b = $urandom();
          pc = $urandom();
          rd = RW'($urandom_range(0, 31));
          size = 2'($urandom_range(0, 3));
          ld_unsigned = ~ld_unsigned;
          mem_write = ~mem_write;
        end
      end else begin
        iv4 = 1'b0;
        check("valid_at_latency", 128'(o), 128'd1);
        check("stall_low_at_done", 128'(s), 128'd0);
      end
    end
    @(negedge clk);
    o  = (sel == 4) ? ov4 : ov1;
    pm = (sel == 4) ? pcm4 : pcm1;
    check("valid_one_cycle", 128'(o), 128'd0);
    check("pcm_zero_when_idle", 128'(pm), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w20;
    logic          trap_build, ab, cb;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_build = 1'b1;
    w20 = 32'h5566_7788;
`else
    trap_build = 1'b0;
    w20 = 32'h5566_ABCD;
`endif
    rst = 1'b1; iv1 = 1'b0; iv4 = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0;
    ld_unsigned = 1'b0; alu_branch = 1'b0; control_branch = 1'b0;
    alu = '0; pc = '0; data_b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(ov1), 128'd0);
    check("rst_stall", 128'(stall1), 128'd0);
    check("rst_state", 128'(st1), 128'(IDLE));
    check("rst_data_out", 128'(dout1), 128'd0);
    check("rst_pcm", 128'(pcm1), 128'd0);
    check("rst_misalign", 128'(mis1), 128'd0);
    check("rst_out_valid4", 128'(ov4), 128'd0);
    check("rst_stall4", 128'(stall4), 128'd0);
    rst = 1'b0;

    // Word store/load round trip, then sign/zero extension of sub-word loads.
    run_op(1, 0, 1, SZ_WORD, 0, 0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd3, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd4, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(1, 0, 1, SZ_WORD, 0, 0, 0, 32'h10, 32'h4, 32'h80FF_0000, 5'd5, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, SZ_BYTE, 0, 0, 0, 32'h13, 32'h4, 32'h0, 5'd6, 32'hFFFF_FF80, 0, 0, 0);
    run_op(1, 1, 0, SZ_BYTE, 1, 0, 0, 32'h13, 32'h4, 32'h0, 5'd7, 32'h0000_0080, 0, 0, 0);
    run_op(1, 1, 0, SZ_HALF, 0, 0, 0, 32'h12, 32'h4, 32'h0, 5'd8, 32'hFFFF_80FF, 0, 0, 0);
    run_op(1, 1, 0, SZ_HALF, 1, 0, 0, 32'h12, 32'h4, 32'h0, 5'd8, 32'h0000_80FF, 0, 0, 0);
    run_op(1, 1, 0, SZ_BYTE, 0, 0, 0, 32'h12, 32'h4, 32'h0, 5'd9, 32'hFFFF_FFFF, 0, 0, 0);

    // Byte and half stores touch only their lanes; high address bits wrap.
    run_op(1, 0, 1, SZ_BYTE, 0, 0, 0, 32'h11, 32'h8, 32'h1234_5678, 5'd10, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h10, 32'h8, 32'h0, 5'd11, 32'h80FF_7800, 0, 0, 0);
    run_op(1, 0, 1, SZ_HALF, 0, 0, 0, 32'h12, 32'h8, 32'hAAAA_BBBB, 5'd12, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h10, 32'h8, 32'h0, 5'd13, 32'hBBBB_7800, 0, 0, 0);
    run_op(1, 0, 1, SZ_WORD, 0, 0, 0, 32'h410, 32'hC, 32'hCAFE_F00D, 5'd14, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h10, 32'hC, 32'h0, 5'd15, 32'hCAFE_F00D, 0, 0, 0);
    run_op(1, 1, 0, SZ_DWORD, 1, 0, 0, 32'h10, 32'hC, 32'h0, 5'd16, 32'hCAFE_F00D, 0, 0, 0);

    // Branch resolution on non-memory ops.
    run_op(1, 0, 0, SZ_WORD, 0, 1, 1, 32'h1234, 32'h40, 32'h0, 5'd17, 32'h0, 1, 0, 0);
    run_op(1, 0, 0, SZ_WORD, 0, 0, 1, 32'h1234, 32'h40, 32'h0, 5'd18, 32'h0, 0, 0, 0);
    run_op(1, 0, 0, SZ_WORD, 0, 1, 0, 32'h1234, 32'h44, 32'h0, 5'd19, 32'h0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] ra, rp;
      logic [RW-1:0] rr;
      ab = 1'($urandom_range(0, 1));
      cb = 1'($urandom_range(0, 1));
      ra = $urandom();
      rp = $urandom();
      rr = RW'($urandom_range(0, 31));
      run_op(1, 0, 0, 2'($urandom_range(0, 3)), 0, ab, cb, ra, rp, $urandom(), rr, 32'h0, ab & cb, 0, 0);
    end

    // Misaligned half store and word load, then read+write treated as a load.
    run_op(1, 0, 1, SZ_WORD, 0, 0, 0, 32'h20, 32'h0, 32'h5566_7788, 5'd20, 32'h0, 0, 0, 0);
    run_op(1, 0, 1, SZ_HALF, 0, 0, 0, 32'h21, 32'h0, 32'h0000_ABCD, 5'd21, 32'h0, 0, trap_build, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h20, 32'h0, 32'h0, 5'd22, w20, 0, 0, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h22, 32'h0, 32'h0, 5'd23, trap_build ? 32'h0 : w20, 0, trap_build, 0);
    run_op(1, 1, 1, SZ_WORD, 0, 0, 0, 32'h20, 32'h0, 32'h0, 5'd24, w20, 0, 0, 0);
    run_op(1, 1, 0, SZ_WORD, 0, 0, 0, 32'h20, 32'h0, 32'h0, 5'd25, w20, 0, 0, 0);

    // Four-cycle memory: non-memory op still takes one edge; inputs wiggled during the stall.
    run_op(4, 0, 0, SZ_WORD, 0, 1, 1, 32'h55, 32'h100, 32'h0, 5'd26, 32'h0, 1, 0, 0);
    run_op(4, 0, 1, SZ_WORD, 0, 0, 0, 32'h20, 32'h100, 32'h1122_3344, 5'd27, 32'h0, 0, 0, 0);
    run_op(4, 1, 0, SZ_WORD, 0, 1, 1, 32'h20, 32'h104, 32'h0, 5'd28, 32'h1122_3344, 1, 0, 1);
    run_op(4, 1, 0, SZ_BYTE, 1, 0, 0, 32'h21, 32'h108, 32'h0, 5'd29, 32'h0000_0033, 0, 0, 1);

    // Reset in the middle of a pending store drops it.
    mem_read = 1'b0; mem_write = 1'b1; size = SZ_WORD; ld_unsigned = 1'b0;
    alu_branch = 1'b1; control_branch = 1'b1; alu = 32'h20; pc = 32'h80;
    data_b = 32'h9999_9999; rd = 5'd30;
    iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    @(negedge clk);
    check("stall_before_reset", 128'(stall4), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("wait_rst_stall", 128'(stall4), 128'd0);
    check("wait_rst_state", 128'(st4), 128'(IDLE));
    check("wait_rst_out_valid", 128'(ov4), 128'd0);
    check("wait_rst_rd_out", 128'(rdo4), 128'd0);
    check("wait_rst_alu_out", 128'(alo4), 128'd0);
    check("wait_rst_data_out", 128'(dout4), 128'd0);
    check("wait_rst_newpc", 128'(npc4), 128'd0);
    check("wait_rst_pcm", 128'(pcm4), 128'd0);
    check("wait_rst_misalign", 128'(mis4), 128'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_op(4, 1, 0, SZ_WORD, 0, 0, 0, 32'h20, 32'h10C, 32'h0, 5'd31, 32'h1122_3344, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("queue_lat1_drained", 128'(exp_q1.size()), 128'd0);
    check("queue_lat4_drained", 128'(exp_q4.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
